// File: rtl/program_loader_pkg.sv
// program_loader_pkg -- shared types and constants for the program loader.
//   state_t       : loader FSM states (CHK exists only with PROGRAM_LOADER_CKSUM_EN)
//   IADDR_STRIDE  : byte stride between instruction words
//   DADDR_STRIDE  : byte stride between data dwords
//   CNT_W         : width of the phase word counters
// Optional feature macro: PROGRAM_LOADER_CKSUM_EN (adds the trailing XOR check word).
package program_loader_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      I_HDR  = 4'd1,
      I_LOAD = 4'd2,
      D_HDR  = 4'd3,
      D_LO   = 4'd4,
      D_HI   = 4'd5,
`ifdef PROGRAM_LOADER_CKSUM_EN
      CHK    = 4'd6,
`endif
      RUN    = 4'd7,
      ERR    = 4'd8
   } state_t;

   localparam int unsigned IADDR_STRIDE = 4;
   localparam int unsigned DADDR_STRIDE = 8;
   localparam int          CNT_W        = 32;

endpackage

// File: rtl/program_loader_word.sv
// loader_word_counter -- per-phase word counter for the program loader.
//   clk, arst   : clock, asynchronous active-high reset
//   i_load      : capture i_limit and clear the count
//   i_limit     : number of words in the phase (header value)
//   i_inc       : one word of the phase was accepted this cycle
//   o_count     : index of the next word of the phase
//   o_done      : the word being counted now is the last of the phase
// 32-bit count and limit; the limit is range-checked before loading, so the
// count never wraps.
module loader_word_counter
   import program_loader_pkg::*;
(
   input  logic             clk,
   input  logic             arst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_limit,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count,
   output logic             o_done
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_limit;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_count <= '0;
         r_limit <= '0;
      end else if (i_load) begin
         r_count <= '0;
         r_limit <= i_limit;
      end else if (i_inc) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
   // Phase ends on the increment that brings the count up to the limit.
   assign o_done  = i_inc && ((r_count + 1'b1) == r_limit);

endmodule

// File: rtl/program_loader.sv
// program_loader -- streams a program image into instruction and data memories,
// then enables the CPU.
//   clk, arst                          : clock, asynchronous active-high reset
//   start                              : one-cycle pulse, begins a load from IDLE
//   s_valid, s_data, s_ready           : upstream 32-bit image stream
//   addr_ext, wen_ext, ren_ext,
//   wdata_ext                          : instruction memory write port (32-bit words)
//   addr_ext_2, wen_ext_2, ren_ext_2,
//   wdata_ext_2                        : data memory write port (64-bit dwords)
//   cpu_enable, busy, error            : run enable and status
// Image: NI, NI instr words, ND, ND dwords (low word first, then high).
// Optional macro PROGRAM_LOADER_CKSUM_EN appends one word equal to the XOR of
// every preceding word; a mismatch sends the loader to ERR.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int IMEM_WORDS = 512,
   parameter int DMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        start,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   output logic        s_ready,
   output logic [63:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   output logic [63:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [63:0] wdata_ext_2,
   output logic        cpu_enable,
   output logic        busy,
   output logic        error
);

`ifdef PROGRAM_LOADER_CKSUM_EN
   localparam state_t POST = CHK;
`else
   localparam state_t POST = RUN;
`endif

   state_t             r_state, w_next;
   logic               w_acc;
   logic [CNT_W-1:0]   w_icnt, w_dcnt;
   logic               w_idone, w_ddone;
   logic               r_wen, r_wen2;
   logic [63:0]        r_addr, r_addr2, r_wdata2;
   logic [31:0]        r_wdata, r_lo;
`ifdef PROGRAM_LOADER_CKSUM_EN
   logic [31:0]        r_xor;
`endif

   assign w_acc = s_valid && s_ready;

   loader_word_counter u_icnt (
      .clk     (clk),
      .arst    (arst),
      .i_load  (w_acc && (r_state == I_HDR)),
      .i_limit (s_data),
      .i_inc   (w_acc && (r_state == I_LOAD)),
      .o_count (w_icnt),
      .o_done  (w_idone)
   );

   loader_word_counter u_dcnt (
      .clk     (clk),
      .arst    (arst),
      .i_load  (w_acc && (r_state == D_HDR)),
      .i_limit (s_data),
      .i_inc   (w_acc && (r_state == D_HI)),
      .o_count (w_dcnt),
      .o_done  (w_ddone)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      s_ready    = 1'b0;
      busy       = 1'b1;
      cpu_enable = 1'b0;
      error      = 1'b0;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) w_next = I_HDR;
         end
         I_HDR: begin
            s_ready = 1'b1;
            if (w_acc) begin
               if (s_data > 32'(IMEM_WORDS)) w_next = ERR;
               else if (s_data == '0)        w_next = D_HDR;
               else                          w_next = I_LOAD;
            end
         end
         I_LOAD: begin
            s_ready = 1'b1;
            if (w_idone) w_next = D_HDR;
         end
         D_HDR: begin
            s_ready = 1'b1;
            if (w_acc) begin
               if (s_data > 32'(DMEM_WORDS)) w_next = ERR;
               else if (s_data == '0)        w_next = POST;
               else                          w_next = D_LO;
            end
         end
         D_LO: begin
            s_ready = 1'b1;
            if (w_acc) w_next = D_HI;
         end
         D_HI: begin
            s_ready = 1'b1;
            if (w_acc) w_next = w_ddone ? POST : D_LO;
         end
`ifdef PROGRAM_LOADER_CKSUM_EN
         CHK: begin
            s_ready = 1'b1;
            if (w_acc) w_next = (s_data == r_xor) ? RUN : ERR;
         end
`endif
         RUN: begin
            busy       = 1'b0;
            cpu_enable = 1'b1;
         end
         ERR: begin
            busy  = 1'b0;
            error = 1'b1;
         end
         default: begin
            busy   = 1'b0;
            w_next = IDLE;
         end
      endcase
   end

   // Write ports are registered: the write appears the cycle after the beat
   // is accepted, and address/data fall back to zero when not writing.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_wen    <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wen2   <= 1'b0;
         r_addr2  <= '0;
         r_wdata2 <= '0;
         r_lo     <= '0;
      end else begin
         r_wen    <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wen2   <= 1'b0;
         r_addr2  <= '0;
         r_wdata2 <= '0;
         if (w_acc && (r_state == I_LOAD)) begin
            r_wen   <= 1'b1;
            r_addr  <= 64'(w_icnt) * 64'(IADDR_STRIDE);
            r_wdata <= s_data;
         end
         if (w_acc && (r_state == D_LO)) r_lo <= s_data;
         if (w_acc && (r_state == D_HI)) begin
            r_wen2   <= 1'b1;
            r_addr2  <= 64'(w_dcnt) * 64'(DADDR_STRIDE);
            r_wdata2 <= {s_data, r_lo};
         end
      end
   end

`ifdef PROGRAM_LOADER_CKSUM_EN
   // Running XOR of every accepted word before the check word itself.
   always_ff @(posedge clk or posedge arst) begin
      if (arst)                        r_xor <= '0;
      else if (r_state == IDLE)        r_xor <= '0;
      else if (w_acc && r_state != CHK) r_xor <= r_xor ^ s_data;
   end
`endif

   assign wen_ext     = r_wen;
   assign addr_ext    = r_addr;
   assign wdata_ext   = r_wdata;
   assign ren_ext     = 1'b0;
   assign wen_ext_2   = r_wen2;
   assign addr_ext_2  = r_addr2;
   assign wdata_ext_2 = r_wdata2;
   assign ren_ext_2   = 1'b0;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader -- scoreboard bench for program_loader.
// Stimulus pushes every expected memory write into a queue; a monitor on the
// falling clock edge pops and compares each write the DUT performs.
// Build with PROGRAM_LOADER_CKSUM_EN to exercise the trailing XOR word.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        arst, start, s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
   logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
   logic [31:0] wdata_ext;
   logic        cpu_enable, busy, error;

   program_loader dut (
      .clk(clk), .arst(arst), .start(start),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .wdata_ext_2(wdata_ext_2),
      .cpu_enable(cpu_enable), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        port;   // 0 = instruction memory, 1 = data memory
      logic [63:0] addr;
      logic [63:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] img[$];
   int          n_vec = 0;
   int          n_err = 0;

   function automatic void cmp(string nm, logic [63:0] act, logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endfunction

   function automatic void chk_wr(logic port, logic [63:0] a, logic [63:0] d);
      wr_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_write: port %0d addr %h data %h, expected none", port, a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.port !== port || e.addr !== a || e.data !== d) begin
            n_err++;
            $display("FAIL write: got port %0d addr %h data %h, expected port %0d addr %h data %h",
                     port, a, d, e.port, e.addr, e.data);
         end
      end
   endfunction

   // Monitor: bus invariants every cycle, scoreboard pop on each write.
   always @(negedge clk) begin
      if (!arst) begin
         cmp("ren_zero", {62'b0, ren_ext, ren_ext_2}, 64'd0);
         if (!wen_ext)   cmp("imem_idle_bus", addr_ext | {32'b0, wdata_ext}, 64'd0);
         if (!wen_ext_2) cmp("dmem_idle_bus", addr_ext_2 | wdata_ext_2, 64'd0);
         if (wen_ext === 1'b1)   chk_wr(1'b0, addr_ext, {32'b0, wdata_ext});
         if (wen_ext_2 === 1'b1) chk_wr(1'b1, addr_ext_2, wdata_ext_2);
      end
   end

   task automatic exp_i(input int k, input logic [31:0] w);
      exp_q.push_back('{port: 1'b0, addr: 64'(k * 4), data: {32'b0, w}});
   endtask

   task automatic exp_d(input int k, input logic [31:0] lo, input logic [31:0] hi);
      exp_q.push_back('{port: 1'b1, addr: 64'(k * 8), data: {hi, lo}});
   endtask

   task automatic do_reset();
      arst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (2) @(negedge clk);
      arst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one word; optional random idle cycles with garbage data.
   task automatic send(input logic [31:0] w, input bit rnd);
      int t;
      bit done;
      t = 0; done = 1'b0;
      while (!done) begin
         if (rnd && $urandom_range(0, 2) == 0) begin
            s_valid = 1'b0; s_data = 32'hDEADBEEF;
         end else begin
            s_valid = 1'b1; s_data = w;
            if (s_ready) done = 1'b1;
         end
         @(negedge clk);
         t++;
         if (!done && t > 200) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: word %h not accepted, s_ready=%b", w, s_ready);
            done = 1'b1;
         end
      end
      s_valid = 1'b0; s_data = '0;
   endtask

   task automatic run_img(input bit rnd);
      foreach (img[i]) send(img[i], rnd);
   endtask

`ifdef PROGRAM_LOADER_CKSUM_EN
   task automatic send_cksum(input bit bad, input bit rnd);
      logic [31:0] x;
      x = '0;
      foreach (img[i]) x ^= img[i];
      send(bad ? (x ^ 32'h1) : x, rnd);
   endtask
`endif

   task automatic check_status(string nm, bit cpu, bit bsy, bit er, bit rdy);
      repeat (2) @(negedge clk);
      cmp({nm, "_cpu_enable"}, {63'b0, cpu_enable}, {63'b0, cpu});
      cmp({nm, "_busy"},       {63'b0, busy},       {63'b0, bsy});
      cmp({nm, "_error"},      {63'b0, error},      {63'b0, er});
      cmp({nm, "_s_ready"},    {63'b0, s_ready},    {63'b0, rdy});
      cmp({nm, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic std_img();
      img = '{32'd2, 32'h00500093, 32'h00A00113, 32'd1, 32'h1, 32'h2};
      exp_i(0, 32'h00500093);
      exp_i(1, 32'h00A00113);
      exp_d(0, 32'h1, 32'h2);
   endtask

   initial begin
      arst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
      #2;
      cmp("reset_outputs", {addr_ext, wen_ext, ren_ext, wen_ext_2, ren_ext_2, s_ready,
                            cpu_enable, busy, error} == '0 ? 64'd0 : 64'd1, 64'd0);
      cmp("reset_wdata", {32'b0, wdata_ext} | wdata_ext_2 | addr_ext_2, 64'd0);
      do_reset();
      check_status("idle", 0, 0, 0, 0);

      // Reference image, continuous stream.
      std_img();
      pulse_start();
      cmp("loading_busy",    {63'b0, busy},    64'd1);
      cmp("loading_s_ready", {63'b0, s_ready}, 64'd1);
      run_img(1'b0);
`ifdef PROGRAM_LOADER_CKSUM_EN
      send_cksum(1'b0, 1'b0);
`endif
      check_status("std_run", 1, 0, 0, 0);
      pulse_start();
      check_status("start_ignored_run", 1, 0, 0, 0);

      // Instruction count one past the memory depth.
      do_reset();
      pulse_start();
      send(32'd513, 1'b0);
      check_status("ni513_err", 0, 0, 1, 0);
      pulse_start();
      check_status("start_ignored_err", 0, 0, 1, 0);

      // Empty image.
      do_reset();
      img = '{32'd0, 32'd0};
      pulse_start();
      run_img(1'b0);
`ifdef PROGRAM_LOADER_CKSUM_EN
      send_cksum(1'b0, 1'b0);
`endif
      check_status("empty_run", 1, 0, 0, 0);

      // Data count one past the memory depth.
      do_reset();
      pulse_start();
      send(32'd0, 1'b0);
      send(32'd1025, 1'b0);
      check_status("nd1025_err", 0, 0, 1, 0);

      // Full instruction memory, no data.
      do_reset();
      img.delete();
      img.push_back(32'd512);
      for (int k = 0; k < 512; k++) begin
         img.push_back(32'(k * 3 + 1));
         exp_i(k, 32'(k * 3 + 1));
      end
      img.push_back(32'd0);
      pulse_start();
      run_img(1'b0);
`ifdef PROGRAM_LOADER_CKSUM_EN
      send_cksum(1'b0, 1'b0);
`endif
      check_status("ni512_run", 1, 0, 0, 0);

      // Reference image with random stalls.
      do_reset();
      std_img();
      pulse_start();
      run_img(1'b1);
`ifdef PROGRAM_LOADER_CKSUM_EN
      send_cksum(1'b0, 1'b1);
`endif
      check_status("stall_run", 1, 0, 0, 0);

      // Reset right after the first instruction write, then reload.
      do_reset();
      exp_i(0, 32'h00500093);
      pulse_start();
      send(32'd2, 1'b0);
      send(32'h00500093, 1'b0);
      @(negedge clk);
      arst = 1'b1;
      #1;
      cmp("midrst_imem", addr_ext | {32'b0, wdata_ext} | {63'b0, wen_ext}, 64'd0);
      cmp("midrst_dmem", addr_ext_2 | wdata_ext_2 | {63'b0, wen_ext_2}, 64'd0);
      cmp("midrst_status", {60'b0, s_ready, cpu_enable, busy, error}, 64'd0);
      cmp("midrst_pending_writes", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      arst = 1'b0;
      @(negedge clk);
      check_status("midrst_idle", 0, 0, 0, 0);
      std_img();
      pulse_start();
      run_img(1'b0);
`ifdef PROGRAM_LOADER_CKSUM_EN
      send_cksum(1'b0, 1'b0);
`endif
      check_status("reload_run", 1, 0, 0, 0);

`ifdef PROGRAM_LOADER_CKSUM_EN
      // Corrupted check word.
      do_reset();
      std_img();
      pulse_start();
      run_img(1'b0);
      send_cksum(1'b1, 1'b0);
      check_status("bad_cksum_err", 0, 0, 1, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 512, meaning the instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 1024, meaning the data memory depth in 64-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port arst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a load.
REQ-006 SHALL have ports s_valid (input, 1), s_data (input, 32) and s_ready (output, 1): the upstream image stream.
REQ-007 SHALL have ports addr_ext (output, 64), wen_ext (output, 1), ren_ext (output, 1) and wdata_ext (output, 32): the instruction-memory external port.
REQ-008 SHALL have ports addr_ext_2 (output, 64), wen_ext_2 (output, 1), ren_ext_2 (output, 1) and wdata_ext_2 (output, 64): the data-memory external port.
REQ-009 SHALL have ports cpu_enable (output, 1), busy (output, 1) and error (output, 1): processor run enable and status.

Function
REQ-010 SHALL accept a stream beat only in a cycle where s_valid and s_ready are both 1.
REQ-011 SHALL parse the image in this order: NI header word, then NI instruction words, then ND header word, then ND data dwords, each dword sent as two words with the low word first.
REQ-012 SHALL implement FSM states IDLE, I_HDR, I_LOAD, D_HDR, D_LO, D_HI, CHK, RUN and ERR.
REQ-013 SHALL drive s_ready to 1 only in I_HDR, I_LOAD, D_HDR, D_LO, D_HI and CHK.
REQ-014 SHALL go from IDLE to I_HDR on start, and SHALL ignore start in every other state.
REQ-015 SHALL go from I_HDR to ERR when NI > IMEM_WORDS, to D_HDR when NI = 0, and to I_LOAD otherwise.
REQ-016 SHALL write the k-th instruction word (k = 0..NI-1) with wen_ext=1, addr_ext=4*k and wdata_ext=word, one cycle after the beat is accepted, with wen_ext high for exactly one cycle.
REQ-017 SHALL go from D_HDR to ERR when ND > DMEM_WORDS, and to the post-data state (REQ-021) when ND = 0.
REQ-018 SHALL write dword k with wen_ext_2=1, addr_ext_2=8*k and wdata_ext_2={hi,lo}, one cycle after the hi beat is accepted, with wen_ext_2 high for exactly one cycle.
REQ-019 SHALL size both word counters to 32 bits so that they cannot wrap; the counter reaching NI (or ND) ends that phase.
REQ-020 SHALL hold ren_ext and ren_ext_2 at 0 at all times, and SHALL keep addr and wdata outputs at 0 whenever their write enable is 0.
REQ-021 SHALL enter RUN after the last data write (the post-data state when PROGRAM_LOADER_CKSUM_EN is undefined).
REQ-022 SHALL hold cpu_enable=1 in RUN until reset, with busy=0 and s_ready=0.
REQ-023 SHALL hold error=1, cpu_enable=0 and s_ready=0 in ERR until reset.
REQ-024 SHALL drive busy to 1 in every state except IDLE, RUN and ERR.
REQ-025 SHALL let a stall (s_valid=0) in any state hold all state and counters unchanged.

Reset
REQ-026 SHALL, while arst=1, immediately force state to IDLE, all counters to 0, and all outputs to 0.
REQ-027 SHALL abandon a load on reset mid-operation, leaving partial memory contents as written with no cleanup.

Configuration
REQ-028 SHALL, with PROGRAM_LOADER_CKSUM_EN defined, make CHK the post-data state: CHK expects one further word equal to the XOR of all preceding accepted words (headers included), going to RUN on a match and to ERR on a mismatch.
REQ-029 SHALL, with PROGRAM_LOADER_CKSUM_EN undefined, omit the CHK state and all checksum logic.

Structure
REQ-030 SHALL take the FSM state enum and the address strides (4, 8) from the shared package program_loader_pkg.
REQ-031 SHALL instantiate one sub-module, loader_word_counter, used twice (once per phase) and providing load, increment and done.

Verification
REQ-032 SHALL cover: start, then stream 2, 0x00500093, 0x00A00113, 1, 0x1, 0x2 -> wen_ext pulses at addr 0 and 4, one wen_ext_2 with addr 0 and data 0x0000000200000001, then cpu_enable=1.
REQ-033 SHALL cover: NI=513 -> error=1, s_ready=0, and no write pulses.
REQ-034 SHALL cover: NI=0, ND=0 -> RUN with no writes.
REQ-035 SHALL cover: s_valid toggled randomly during the REQ-032 image -> identical writes in identical order.
REQ-036 SHALL cover: arst asserted after the first instruction write -> outputs 0 and state IDLE; a subsequent start with the full image -> correct load.
REQ-037 SHALL cover, with PROGRAM_LOADER_CKSUM_EN defined: the REQ-032 image plus a correct XOR word -> RUN; the same image with a corrupted XOR word -> ERR.
